// File: rtl/affine_inverse_solver.sv
// rtl/affine_inverse_solver.sv - back-solver a = b + (2y + 4d) / (1 + 3c) using a sequential restoring divider
// Optional macro INV_FWD_CHECK_EN adds chk_ok and a forward re-check state.
module affine_inverse_solver #(
    parameter int WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [2*WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0]   b,
    input  logic signed [WIDTH-1:0]   c,
    input  logic signed [WIDTH-1:0]   d,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   a,
    output logic                      exact,
`ifdef INV_FWD_CHECK_EN
    output logic                      chk_ok,
`endif
    output logic                      ovf
);

    localparam int NW = 2*WIDTH + 2;
    localparam int DW = WIDTH + 2;
    localparam int RW = DW + 1;
    localparam int AW = 2*WIDTH + 3;
    localparam int CW = $clog2(NW + 1);
    localparam logic [DW-1:0] ONE_D = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_FIX,
`ifdef INV_FWD_CHECK_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [2*WIDTH-1:0] y_r;
    logic [WIDTH-1:0]   b_r, c_r, d_r;
    logic [NW-1:0]      q_sh;
    logic [DW-1:0]      den_mag;
    logic [RW-1:0]      rem_r;
    logic               neg_q;
    logic [CW-1:0]      cnt;

    logic [NW-1:0] y_ext, d_ext, num_full, num_abs;
    logic [DW-1:0] c_ext, den_full, den_abs;
    logic [RW-1:0] rem_sh, den_cmp, rem_nx;
    logic          ge;
    logic [AW-1:0] q_ext, q_val, b_ext, a_full;

    // Operands are widened before scaling so num and den never wrap.
    always_comb begin
        y_ext    = {{(NW-2*WIDTH){y_r[2*WIDTH-1]}}, y_r};
        d_ext    = {{(NW-WIDTH){d_r[WIDTH-1]}}, d_r};
        num_full = {y_ext[NW-2:0], 1'b0} + {d_ext[NW-3:0], 2'b00};
        num_abs  = num_full[NW-1] ? -num_full : num_full;
        c_ext    = {{(DW-WIDTH){c_r[WIDTH-1]}}, c_r};
        den_full = c_ext + {c_ext[DW-2:0], 1'b0} + ONE_D;
        den_abs  = den_full[DW-1] ? -den_full : den_full;
    end

    // One restoring step: quotient bits shift in where dividend bits shift out.
    always_comb begin
        rem_sh  = {rem_r[RW-2:0], q_sh[NW-1]};
        den_cmp = {1'b0, den_mag};
        ge      = (rem_sh >= den_cmp);
        rem_nx  = ge ? (rem_sh - den_cmp) : rem_sh;
    end

    always_comb begin
        q_ext  = {{(AW-NW){1'b0}}, q_sh};
        q_val  = neg_q ? -q_ext : q_ext;
        b_ext  = {{(AW-WIDTH){b_r[WIDTH-1]}}, b_r};
        a_full = b_ext + q_val;
    end

`ifdef INV_FWD_CHECK_EN
    logic [WIDTH-1:0]          diff_w, den_w;
    logic signed [2*WIDTH-1:0] diff_e, den_e, d4_e, fwd_prod, fwd;

    // Re-run the forward datapath with its own WIDTH-bit wrapping.
    always_comb begin
        diff_w   = a - b_r;
        den_w    = c_r + {c_r[WIDTH-2:0], 1'b0} + {{(WIDTH-1){1'b0}}, 1'b1};
        diff_e   = {{WIDTH{diff_w[WIDTH-1]}}, diff_w};
        den_e    = {{WIDTH{den_w[WIDTH-1]}}, den_w};
        d4_e     = {{(WIDTH-2){d_r[WIDTH-1]}}, d_r, 2'b00};
        fwd_prod = diff_e * den_e - d4_e;
        fwd      = fwd_prod >>> 1;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_PREP;
            end
            S_PREP: state_nx = S_DIV;
            S_DIV:  if (cnt == CW'(1)) state_nx = S_FIX;
`ifdef INV_FWD_CHECK_EN
            S_FIX:   state_nx = S_CHECK;
            S_CHECK: state_nx = S_DONE;
`else
            S_FIX:   state_nx = S_DONE;
`endif
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            d_r     <= '0;
            q_sh    <= '0;
            den_mag <= '0;
            rem_r   <= '0;
            neg_q   <= 1'b0;
            cnt     <= '0;
            a       <= '0;
            exact   <= 1'b0;
            ovf     <= 1'b0;
`ifdef INV_FWD_CHECK_EN
            chk_ok  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        y_r <= y;
                        b_r <= b;
                        c_r <= c;
                        d_r <= d;
                    end
                end
                S_PREP: begin
                    q_sh    <= num_abs;
                    den_mag <= den_abs;
                    rem_r   <= '0;
                    neg_q   <= num_full[NW-1] ^ den_full[DW-1];
                    cnt     <= CW'(NW);
                end
                S_DIV: begin
                    q_sh  <= {q_sh[NW-2:0], ge};
                    rem_r <= rem_nx;
                    cnt   <= cnt - CW'(1);
                end
                S_FIX: begin
                    a     <= a_full[WIDTH-1:0];
                    exact <= (rem_r == '0);
                    ovf   <= !((&a_full[AW-1:WIDTH-1]) || (~|a_full[AW-1:WIDTH-1]));
                end
`ifdef INV_FWD_CHECK_EN
                S_CHECK: chk_ok <= (fwd == $signed(y_r));
`endif
                default: ;
            endcase
        end
    end

endmodule
